debug_trace_arbiter: RTL and testbench



---
 rtl/debug_trace_arbiter.sv | 167 ++++++++++++++++
 tb/tb_debug_trace_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_trace_arbiter.sv
// Merges the two retire lanes into one in-order trace stream through a FIFO.
// Optional DEBUG_TRACE_PERF_EN adds retired-instruction and run-cycle counters.
module debug_trace_arbiter #(
   parameter  int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             soc_clk,
   input  logic             resetn,
   input  logic             trace_en,
   input  logic             end_req,
   input  logic             in1_valid,
   input  logic [31:0]      in1_pc,
   input  logic [4:0]       in1_dest,
   input  logic [3:0]       in1_wstrb,
   input  logic [31:0]      in1_wdata,
   input  logic             in2_valid,
   input  logic [31:0]      in2_pc,
   input  logic [4:0]       in2_dest,
   input  logic [3:0]       in2_wstrb,
   input  logic [31:0]      in2_wdata,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_pc,
   output logic [4:0]       out_dest,
   output logic [3:0]       out_wstrb,
   output logic [31:0]      out_wdata,
   output logic             out_lane,
   output logic [PTR_W:0]   occupancy,
   output logic             overflow,
`ifdef DEBUG_TRACE_PERF_EN
   output logic [31:0]      perf_inst_count,
   output logic [31:0]      perf_cycle_count,
`endif
   output logic             done
);

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  dest;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic        lane;
   } rec_t;

   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] ONE  = (PTR_W+1)'(1);

   function automatic logic [31:0] mask_wdata(input logic [31:0] w,
                                              input logic [3:0]  s);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) m[8*i +: 8] = w[8*i +: 8] & {8{s[i]}};
      return m;
   endfunction

   rec_t             mem_q [DEPTH];
   rec_t             mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   occ_q, occ_d;
   logic             overflow_q, overflow_d;
   state_t           state_q, state_d;

   logic             run, q1, q2, wr1, wr2, deq, head_valid;
   logic [PTR_W:0]   free;
   logic [1:0]       enq_cnt;
   rec_t             rec1, rec2, head;

`ifdef DEBUG_TRACE_PERF_EN
   logic [31:0]      perf_inst_q, perf_inst_d;
   logic [31:0]      perf_cyc_q, perf_cyc_d;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:     if (end_req) state_d = DRAIN;
         DRAIN:   if (occ_q == '0) state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      run  = (state_q == RUN);
      q1   = in1_valid && (in1_wstrb != '0) && (in1_dest != '0) && trace_en && run;
      q2   = in2_valid && (in2_wstrb != '0) && (in2_dest != '0) && trace_en && run;
      // Room is judged on the pre-dequeue count only.
      free = FULL - occ_q;
      wr1  = q1 && (free != '0);
      wr2  = q2 && (q1 ? (free > ONE) : (free != '0));

      rec1 = '{pc: in1_pc, dest: in1_dest, wstrb: in1_wstrb,
               wdata: mask_wdata(in1_wdata, in1_wstrb), lane: 1'b0};
      rec2 = '{pc: in2_pc, dest: in2_dest, wstrb: in2_wstrb,
               wdata: mask_wdata(in2_wdata, in2_wstrb), lane: 1'b1};

      mem_d = mem_q;
      if (wr1) mem_d[wr_ptr_q] = rec1;
      if (wr2) mem_d[wr_ptr_q + PTR_W'(wr1)] = rec2;

      enq_cnt    = {1'b0, wr1} + {1'b0, wr2};
      head_valid = (occ_q != '0) && (state_q != DONE);
      deq        = head_valid && out_ready;

      wr_ptr_d   = wr_ptr_q + PTR_W'(enq_cnt);
      rd_ptr_d   = rd_ptr_q + PTR_W'(deq);
      occ_d      = occ_q + (PTR_W+1)'(enq_cnt) - (PTR_W+1)'(deq);
      overflow_d = overflow_q || (q1 && !wr1) || (q2 && !wr2);

      head = head_valid ? mem_q[rd_ptr_q] : '0;
   end

`ifdef DEBUG_TRACE_PERF_EN
   always_comb begin
      perf_inst_d = perf_inst_q;
      perf_cyc_d  = perf_cyc_q;
      if (state_q == RUN) begin
         perf_inst_d = perf_inst_q + 32'(in1_valid) + 32'(in2_valid);
         perf_cyc_d  = perf_cyc_q + 32'd1;
      end
   end
`endif

   always_ff @(posedge soc_clk) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         overflow_q <= 1'b0;
         state_q    <= RUN;
`ifdef DEBUG_TRACE_PERF_EN
         perf_inst_q <= '0;
         perf_cyc_q  <= '0;
`endif
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
`ifdef DEBUG_TRACE_PERF_EN
         perf_inst_q <= perf_inst_d;
         perf_cyc_q  <= perf_cyc_d;
`endif
      end
   end

   assign out_valid = head_valid;
   assign out_pc    = head.pc;
   assign out_dest  = head.dest;
   assign out_wstrb = head.wstrb;
   assign out_wdata = head.wdata;
   assign out_lane  = head.lane;
   assign occupancy = occ_q;
   assign overflow  = overflow_q;
   assign done      = (state_q == DONE);
`ifdef DEBUG_TRACE_PERF_EN
   assign perf_inst_count  = perf_inst_q;
   assign perf_cycle_count = perf_cyc_q;
`endif

endmodule

// File: tb/tb_debug_trace_arbiter.sv
// Scoreboard bench for debug_trace_arbiter: directed stimulus pushes expected
// records, a negedge monitor pops and compares every accepted output.
module tb_debug_trace_arbiter;

   logic        soc_clk = 1'b0;
   logic        resetn, trace_en, end_req;
   logic        in1_valid, in2_valid;
   logic [31:0] in1_pc, in1_wdata, in2_pc, in2_wdata;
   logic [4:0]  in1_dest, in2_dest;
   logic [3:0]  in1_wstrb, in2_wstrb;
   logic        out_valid, out_ready, out_lane, overflow, done;
   logic [31:0] out_pc, out_wdata;
   logic [4:0]  out_dest;
   logic [3:0]  out_wstrb;
   logic [3:0]  occupancy;
`ifdef DEBUG_TRACE_PERF_EN
   logic [31:0] perf_inst_count, perf_cycle_count;
   logic [31:0] pc0, pi0;
`endif

   always #5 soc_clk = ~soc_clk;

   debug_trace_arbiter #(.DEPTH(8)) dut (
      .soc_clk(soc_clk), .resetn(resetn), .trace_en(trace_en),
      .end_req(end_req),
      .in1_valid(in1_valid), .in1_pc(in1_pc), .in1_dest(in1_dest),
      .in1_wstrb(in1_wstrb), .in1_wdata(in1_wdata),
      .in2_valid(in2_valid), .in2_pc(in2_pc), .in2_dest(in2_dest),
      .in2_wstrb(in2_wstrb), .in2_wdata(in2_wdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_dest(out_dest), .out_wstrb(out_wstrb), .out_wdata(out_wdata),
      .out_lane(out_lane), .occupancy(occupancy), .overflow(overflow),
`ifdef DEBUG_TRACE_PERF_EN
      .perf_inst_count(perf_inst_count), .perf_cycle_count(perf_cycle_count),
`endif
      .done(done)
   );

   typedef logic [73:0] rec_t;
   rec_t exp_q[$];
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [79:0] act,
                      input logic [79:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: scoreboard pop on every handshake, stability while stalled.
   rec_t cur, held, e;
   bit   stall = 1'b0;
   always @(negedge soc_clk) begin
      cur = {out_pc, out_dest, out_wstrb, out_wdata, out_lane};
      if (resetn) begin
         if (out_valid) begin
            if (stall) chk("stall_stable", 80'(cur), 80'(held));
            if (out_ready) begin
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_rec: got %0h expected none", cur);
               end else begin
                  e = exp_q.pop_front();
                  chk("rec", 80'(cur), 80'(e));
               end
            end
         end else begin
            chk("idle_zero", 80'(cur), 80'(0));
         end
      end
      stall = resetn && out_valid && !out_ready;
      held  = cur;
   end

   task automatic cyc();
      @(posedge soc_clk);
      #1;
   endtask

   task automatic idle();
      in1_valid = 0; in1_pc = 0; in1_dest = 0; in1_wstrb = 0; in1_wdata = 0;
      in2_valid = 0; in2_pc = 0; in2_dest = 0; in2_wstrb = 0; in2_wdata = 0;
   endtask

   task automatic lane1(input logic [31:0] pc, input logic [4:0] d,
                        input logic [3:0] s, input logic [31:0] w);
      in1_valid = 1; in1_pc = pc; in1_dest = d; in1_wstrb = s; in1_wdata = w;
   endtask

   task automatic lane2(input logic [31:0] pc, input logic [4:0] d,
                        input logic [3:0] s, input logic [31:0] w);
      in2_valid = 1; in2_pc = pc; in2_dest = d; in2_wstrb = s; in2_wdata = w;
   endtask

   task automatic push(input logic [31:0] pc, input logic [4:0] d,
                       input logic [3:0] s, input logic [31:0] w,
                       input logic lane);
      exp_q.push_back({pc, d, s, w, lane});
   endtask

   // Full-strobe dual record; p1/p2 say which lanes are expected to be stored.
   task automatic dual(input logic [31:0] pc, input bit p1, input bit p2);
      lane1(pc, 5'd1, 4'hf, ~pc);
      lane2(pc + 4, 5'd2, 4'hf, ~(pc + 4));
      if (p1) push(pc, 5'd1, 4'hf, ~pc, 1'b0);
      if (p2) push(pc + 4, 5'd2, 4'hf, ~(pc + 4), 1'b1);
   endtask

   task automatic wait_empty(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge soc_clk);
         if (exp_q.size() == 0 && !out_valid) begin
            cyc();
            return;
         end
      end
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      cyc();
   endtask

   task automatic do_reset();
      resetn = 0; end_req = 0; idle();
      repeat (2) cyc();
      exp_q.delete();
      resetn = 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      trace_en = 1; out_ready = 1;
      do_reset();
      chk("rst_valid", 80'(out_valid), 80'(0));
      chk("rst_occ", 80'(occupancy), 80'(0));
      chk("rst_ovf", 80'(overflow), 80'(0));
      chk("rst_done", 80'(done), 80'(0));
      chk("rst_pc", 80'(out_pc), 80'(0));

      // Dual enqueue, lane order
      lane1(32'hbfc00000, 5'd2, 4'hf, 32'h11223344);
      lane2(32'hbfc00004, 5'd3, 4'hf, 32'h55667788);
      push(32'hbfc00000, 5'd2, 4'hf, 32'h11223344, 1'b0);
      push(32'hbfc00004, 5'd3, 4'hf, 32'h55667788, 1'b1);
      @(negedge soc_clk);
      chk("not_early", 80'(out_valid), 80'(0));
      cyc(); idle();
      wait_empty(10);
      chk("t1_occ", 80'(occupancy), 80'(0));

      // Filtering, masking, trace_en gating
      lane1(32'h200, 5'd0, 4'hf, 32'h1);
      lane2(32'h204, 5'd5, 4'b0011, 32'haabbccdd);
      push(32'h204, 5'd5, 4'b0011, 32'h0000ccdd, 1'b1);
      cyc();
      lane1(32'h208, 5'd6, 4'h0, 32'hffffffff);
      lane2(32'h20c, 5'd7, 4'h0, 32'hffffffff);
      cyc();
      trace_en = 0;
      lane1(32'h210, 5'd8, 4'hf, 32'h12345678);
      cyc();
      trace_en = 1; idle();
      wait_empty(10);
      chk("t2_occ", 80'(occupancy), 80'(0));

      // Partial space: 7 held, dual stores lane 1 only
      out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         dual(32'h300 + 32'(16 * i), 1, 1);
         cyc();
      end
      lane1(32'h330, 5'd9, 4'hf, 32'hcafef00d);
      push(32'h330, 5'd9, 4'hf, 32'hcafef00d, 1'b0);
      in2_valid = 0;
      cyc(); idle();
      chk("p_occ7", 80'(occupancy), 80'(7));
      chk("p_ovf0", 80'(overflow), 80'(0));
      dual(32'h340, 1, 0);
      cyc(); idle();
      chk("p_occ8", 80'(occupancy), 80'(8));
      chk("p_ovf1", 80'(overflow), 80'(1));
      out_ready = 1;
      wait_empty(20);

      // Full FIFO overflow
      do_reset();
      out_ready = 0;
      for (int i = 0; i < 4; i++) begin
         dual(32'h400 + 32'(8 * i), 1, 1);
         cyc();
      end
      idle();
      chk("o_occ8", 80'(occupancy), 80'(8));
      chk("o_ovf0", 80'(overflow), 80'(0));
      dual(32'h480, 0, 0);
      cyc(); idle();
      chk("o_occ_hold", 80'(occupancy), 80'(8));
      chk("o_ovf1", 80'(overflow), 80'(1));
      chk("o_head", 80'(out_pc), 80'(32'h400));
      out_ready = 1;
      wait_empty(20);
      chk("o_ovf_sticky", 80'(overflow), 80'(1));

      // Reset discards buffered records
      out_ready = 0;
      dual(32'h500, 0, 0);
      cyc(); idle();
      chk("r_occ2", 80'(occupancy), 80'(2));
      do_reset();
      chk("r_occ0", 80'(occupancy), 80'(0));
      chk("r_valid", 80'(out_valid), 80'(0));
      chk("r_ovf", 80'(overflow), 80'(0));

      // Backpressure with ready toggling
      for (int i = 0; i < 30; i++) begin
         out_ready = i[0];
         if (i < 3) dual(32'h600 + 32'(8 * i), 1, 1);
         else idle();
         cyc();
      end
      out_ready = 1;
      wait_empty(10);

      // End-of-test drain
      out_ready = 0;
      dual(32'h700, 1, 1);
      cyc();
      lane1(32'h708, 5'd4, 4'hf, 32'h708);
      push(32'h708, 5'd4, 4'hf, 32'h708, 1'b0);
      in2_valid = 0;
      cyc();
      chk("d_occ3", 80'(occupancy), 80'(3));
      end_req = 1;
      lane1(32'h710, 5'd6, 4'b1000, 32'h89abcdef);
      push(32'h710, 5'd6, 4'b1000, 32'h89000000, 1'b0);
`ifdef DEBUG_TRACE_PERF_EN
      pc0 = perf_cycle_count; pi0 = perf_inst_count;
`endif
      cyc();
      dual(32'h720, 0, 0);
      cyc();
      end_req = 0; idle();
      chk("d_occ4", 80'(occupancy), 80'(4));
      chk("d_done0", 80'(done), 80'(0));
      out_ready = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge soc_clk);
         if (occupancy == 0) break;
      end
      chk("d_occ_zero", 80'(occupancy), 80'(0));
      chk("d_done_late", 80'(done), 80'(0));
      @(negedge soc_clk);
      chk("d_done1", 80'(done), 80'(1));
      chk("d_valid0", 80'(out_valid), 80'(0));
      cyc();
      dual(32'h800, 0, 0);
      end_req = 1;
      repeat (3) cyc();
      end_req = 0; idle();
      chk("d_ignore_occ", 80'(occupancy), 80'(0));
      chk("d_stay_done", 80'(done), 80'(1));
      chk("d_pending", 80'(exp_q.size()), 80'(0));
`ifdef DEBUG_TRACE_PERF_EN
      chk("perf_cyc_frozen", 80'(perf_cycle_count), 80'(pc0 + 1));
      chk("perf_inst_frozen", 80'(perf_inst_count), 80'(pi0 + 1));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
